// File: rtl/enc8x3_req_latch_pkg.sv
// enc8x3_req_latch_pkg: shared sizes, priority default and state encodings
package enc8x3_req_latch_pkg;
    localparam int N = 8;
    localparam int CODE_W = 3;
    localparam bit MSB_FIRST_DEF = 1'b1;
    localparam logic IDLE = 1'b0;
    localparam logic PRESENT = 1'b1;
endpackage

// File: rtl/enc8x3_req_latch_prio.sv
// prio_enc8x3: combinational N-to-CODE_W priority encoder with any-bit flag
module prio_enc8x3 #(
    parameter int N = 8,
    parameter int CODE_W = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [N-1:0]      vec,
    output logic [CODE_W-1:0] code,
    output logic              any
);
    // later loop iterations override earlier ones, so scan toward the winning end
    always_comb begin
        code = '0;
        for (int i = 0; i < N; i++) begin
            if (MSB_FIRST ? vec[i] : vec[N-1-i]) code = MSB_FIRST ? CODE_W'(i) : CODE_W'(N-1-i);
        end
    end
    assign any = |vec;
endmodule

// File: rtl/enc8x3_req_latch.sv
// enc8x3_req_latch: latched request priority encoder with valid/ack handshake and overrun flag
module enc8x3_req_latch
    import enc8x3_req_latch_pkg::*;
#(
    parameter int N = enc8x3_req_latch_pkg::N,
    parameter int CODE_W = enc8x3_req_latch_pkg::CODE_W,
    parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [N-1:0]      req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N-1:0]      pend,
    output logic              overrun
);
    logic              state;
    logic [N-1:0]      taken, newreq, pend_next;
    logic [CODE_W-1:0] prio_code;
    logic              prio_any;

    assign taken = (state == PRESENT && ack) ? N'(1) << code : '0;
    assign newreq = en ? req : '0;
    assign pend_next = (pend & ~taken) | newreq;
    assign valid = state;

    prio_enc8x3 #(.N(N), .CODE_W(CODE_W), .MSB_FIRST(MSB_FIRST)) u_prio (
        .vec (pend_next),
        .code(prio_code),
        .any (prio_any)
    );

    // a new code is loaded only when idle or when the current one is acked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            code <= '0;
            state <= IDLE;
            overrun <= 1'b0;
        end else if (clr) begin
            pend <= '0;
            code <= '0;
            state <= IDLE;
            overrun <= 1'b0;
        end else begin
            pend <= pend_next;
            overrun <= overrun | (|(newreq & pend & ~taken));
            if (state == IDLE || ack) begin
                state <= prio_any ? PRESENT : IDLE;
                code <= prio_any ? prio_code : '0;
            end
        end
    end
endmodule

// File: tb/tb_enc8x3_req_latch.sv
// tb_enc8x3_req_latch: directed scoreboard bench for enc8x3_req_latch
module tb_enc8x3_req_latch;
    logic       clk = 1'b0;
    logic       rst_n, en, clr, ack;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid, overrun;
    logic [7:0] pend;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string      tag;
        logic       v;
        logic [2:0] c;
        logic [7:0] p;
        logic       o;
    } exp_t;
    exp_t sb[$];

    enc8x3_req_latch dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req), .ack(ack),
        .code(code), .valid(valid), .pend(pend), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic v, input logic [2:0] c, input logic [7:0] p, input logic o);
        exp_t x;
        x.tag = tag; x.v = v; x.c = c; x.p = p; x.o = o;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        x = sb.pop_front();
        checks++;
        assert ({valid, code, pend, overrun} === {x.v, x.c, x.p, x.o}) else begin
            errors++;
            $error("FAIL %s: got valid=%b code=%0d pend=%h overrun=%b, expected valid=%b code=%0d pend=%h overrun=%b",
                   x.tag, valid, code, pend, overrun, x.v, x.c, x.p, x.o);
        end
    endtask

    // drive one cycle of stimulus, record the expected post-edge outputs, then compare
    task automatic cyc(input string tag, input logic [7:0] r, input logic e, input logic a, input logic cl,
                       input logic v, input logic [2:0] c, input logic [7:0] p, input logic o);
        req = r; en = e; ack = a; clr = cl;
        expect_out(tag, v, c, p, o);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst_n = 1'b0; req = 8'hFF; en = 1'b1; ack = 1'b0; clr = 1'b0;
        #3;
        expect_out("reset", 0, 0, 8'h00, 0);
        check_out();
        cyc("reset_held", 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0);
        rst_n = 1'b1;
        cyc("idle", 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        cyc("single_req", 8'h10, 1, 0, 0, 1, 4, 8'h10, 0);
        cyc("single_ack", 8'h00, 1, 1, 0, 0, 0, 8'h00, 0);
        cyc("multi_req", 8'h85, 1, 0, 0, 1, 7, 8'h85, 0);
        cyc("b2b_2", 8'h00, 1, 1, 0, 1, 2, 8'h05, 0);
        cyc("b2b_0", 8'h00, 1, 1, 0, 1, 0, 8'h01, 0);
        cyc("b2b_done", 8'h00, 1, 1, 0, 0, 0, 8'h00, 0);
        cyc("hold_present", 8'h04, 1, 0, 0, 1, 2, 8'h04, 0);
        cyc("hold_inject", 8'h80, 1, 0, 0, 1, 2, 8'h84, 0);
        cyc("hold_ack", 8'h00, 1, 1, 0, 1, 7, 8'h80, 0);
        cyc("hold_drain", 8'h00, 1, 1, 0, 0, 0, 8'h00, 0);
        cyc("ovr_present", 8'h04, 1, 0, 0, 1, 2, 8'h04, 0);
        cyc("ovr_same_ack", 8'h04, 1, 1, 0, 1, 2, 8'h04, 0);
        cyc("ovr_set", 8'h04, 1, 0, 0, 1, 2, 8'h04, 1);
        cyc("ovr_sticky", 8'h00, 1, 1, 0, 0, 0, 8'h00, 1);
        cyc("clr", 8'hFF, 1, 0, 1, 0, 0, 8'h00, 0);
        cyc("ack_idle", 8'h00, 1, 1, 0, 0, 0, 8'h00, 0);
        cyc("en_low_idle", 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0);
        cyc("en_present", 8'h02, 1, 0, 0, 1, 1, 8'h02, 0);
        cyc("en_low_hold", 8'hFF, 0, 0, 0, 1, 1, 8'h02, 0);
        cyc("en_low_serve", 8'h00, 0, 1, 0, 0, 0, 8'h00, 0);
        cyc("pre_async", 8'h20, 1, 0, 0, 1, 5, 8'h20, 0);
        req = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 8'h00, 0);
        check_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
